pupil_centroid: RTL and testbench

- Consumes the registered Camera Link stream (two pixels per clock, L tap = even x, R tap = odd x) and marks a pixel dark when its value < iTHRESHOLD.
- Over each frame it accumulates the x sum, y sum and count of dark pixels. At frame end it divides the sums by the count with one shared sequential divider.
- Produces the pupil centre (oPOINT_X, oPOINT_Y), which replaces the fixed marker position fed to the VGA overlay.

---
 rtl/pupil_centroid_if.sv | 32 +++
 rtl/pupil_centroid.sv | 176 +++++++++++++++++
 tb/tb_pupil_centroid.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pupil_centroid_if.sv
// Camera Link stream in / centroid result out for pupil_centroid.
// CENTROID_ROI_EN adds the region-of-interest bounds to the bundle.
interface pupil_centroid_if #(
  parameter int X_WIDTH   = 10,
  parameter int Y_WIDTH   = 10,
  parameter int CNT_WIDTH = 19
);
  logic                 iFVAL, iLVAL, iDVAL;
  logic [7:0]           iDATA_L, iDATA_R, iTHRESHOLD;
`ifdef CENTROID_ROI_EN
  logic [X_WIDTH-1:0]   iROI_X0, iROI_X1;
  logic [Y_WIDTH-1:0]   iROI_Y0, iROI_Y1;
`endif
  logic [X_WIDTH-1:0]   oPOINT_X;
  logic [Y_WIDTH-1:0]   oPOINT_Y;
  logic [CNT_WIDTH-1:0] oCOUNT;
  logic                 oVALID, oFOUND, oBUSY, oDROP;

`ifdef CENTROID_ROI_EN
  modport master (output iFVAL, iLVAL, iDVAL, iDATA_L, iDATA_R, iTHRESHOLD,
                         iROI_X0, iROI_X1, iROI_Y0, iROI_Y1,
                  input  oPOINT_X, oPOINT_Y, oCOUNT, oVALID, oFOUND, oBUSY, oDROP);
  modport slave  (input  iFVAL, iLVAL, iDVAL, iDATA_L, iDATA_R, iTHRESHOLD,
                         iROI_X0, iROI_X1, iROI_Y0, iROI_Y1,
                  output oPOINT_X, oPOINT_Y, oCOUNT, oVALID, oFOUND, oBUSY, oDROP);
`else
  modport master (output iFVAL, iLVAL, iDVAL, iDATA_L, iDATA_R, iTHRESHOLD,
                  input  oPOINT_X, oPOINT_Y, oCOUNT, oVALID, oFOUND, oBUSY, oDROP);
  modport slave  (input  iFVAL, iLVAL, iDVAL, iDATA_L, iDATA_R, iTHRESHOLD,
                  output oPOINT_X, oPOINT_Y, oCOUNT, oVALID, oFOUND, oBUSY, oDROP);
`endif
endinterface

// File: rtl/pupil_centroid.sv
// Dark-pixel centroid of each camera frame, one shared restoring divider for x and y.
// Define CENTROID_ROI_EN to restrict accumulation to a per-frame region of interest.
module pupil_centroid #(
  parameter int X_WIDTH   = 10,
  parameter int Y_WIDTH   = 10,
  parameter int CNT_WIDTH = 19,
  parameter int SUM_WIDTH = 29,
  parameter int MIN_COUNT = 4
)(
  input  logic           CLK,
  input  logic           RST,
  pupil_centroid_if.slave bus
);
  localparam int BW = $clog2(SUM_WIDTH + 1);
  localparam int CW = X_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;
  state_t state, state_nx;

  logic       fval_r, lval_r, dval_r, fval_d, lval_d;
  logic [7:0] data_l_r, data_r_r, thr_r;

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      {fval_r, lval_r, dval_r, fval_d, lval_d} <= '0;
      data_l_r <= '0; data_r_r <= '0; thr_r <= '0;
    end else begin
      fval_r   <= bus.iFVAL;  lval_r   <= bus.iLVAL;  dval_r <= bus.iDVAL;
      data_l_r <= bus.iDATA_L; data_r_r <= bus.iDATA_R; thr_r <= bus.iTHRESHOLD;
      fval_d   <= fval_r;     lval_d   <= lval_r;
    end

  logic frame_start, frame_end, line_end, beat;
  assign frame_start = fval_r & ~fval_d;
  assign frame_end   = ~fval_r & fval_d;
  assign line_end    = ~lval_r & lval_d;
  assign beat        = fval_r & lval_r & dval_r;

  logic [CW-1:0]      col;
  logic [Y_WIDTH-1:0] y;
  logic [X_WIDTH-1:0] x_l, x_r;
  logic               hit_l, hit_r;
  assign x_l = {col, 1'b0};
  assign x_r = {col, 1'b1};

`ifdef CENTROID_ROI_EN
  logic [X_WIDTH-1:0] roi_x0, roi_x1;
  logic [Y_WIDTH-1:0] roi_y0, roi_y1;
  logic               y_in;

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      roi_x0 <= '0; roi_x1 <= '0; roi_y0 <= '0; roi_y1 <= '0;
    end else if (frame_start) begin
      roi_x0 <= bus.iROI_X0; roi_x1 <= bus.iROI_X1;
      roi_y0 <= bus.iROI_Y0; roi_y1 <= bus.iROI_Y1;
    end

  assign y_in  = (y >= roi_y0) && (y <= roi_y1);
  assign hit_l = (data_l_r < thr_r) && y_in && (x_l >= roi_x0) && (x_l <= roi_x1);
  assign hit_r = (data_r_r < thr_r) && y_in && (x_r >= roi_x0) && (x_r <= roi_x1);
`else
  assign hit_l = data_l_r < thr_r;
  assign hit_r = data_r_r < thr_r;
`endif

  logic [SUM_WIDTH-1:0] sum_x, sum_y, add_x, add_y;
  logic [CNT_WIDTH-1:0] cnt, add_c;
  assign add_x = (hit_l ? SUM_WIDTH'(x_l) : '0) + (hit_r ? SUM_WIDTH'(x_r) : '0);
  assign add_y = (hit_l ? SUM_WIDTH'(y) : '0) + (hit_r ? SUM_WIDTH'(y) : '0);
  assign add_c = CNT_WIDTH'(hit_l) + CNT_WIDTH'(hit_r);

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      sum_x <= '0; sum_y <= '0; cnt <= '0; col <= '0; y <= '0;
    end else if (frame_start) begin
      sum_x <= '0; sum_y <= '0; cnt <= '0; col <= '0; y <= '0;
    end else begin
      if (beat) begin
        sum_x <= sum_x + add_x;
        sum_y <= sum_y + add_y;
        cnt   <= cnt + add_c;
      end
      if (line_end) begin
        col <= '0;
        if (fval_r) y <= y + Y_WIDTH'(1);
      end else if (beat) begin
        col <= col + CW'(1);
      end
    end

  // dq shifts the dividend out of the top while quotient bits enter at the bottom
  logic [SUM_WIDTH-1:0] dq, dq_nx, hold_y, q_x;
  logic [CNT_WIDTH-1:0] hold_cnt, rem;
  logic [CNT_WIDTH:0]   rem_sh, rem_diff;
  logic [BW-1:0]        bit_cnt;
  logic                 q_bit, last_bit, enough, found;

  assign rem_sh   = {rem, dq[SUM_WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, hold_cnt};
  assign q_bit    = rem_sh >= {1'b0, hold_cnt};
  assign dq_nx    = {dq[SUM_WIDTH-2:0], q_bit};
  assign last_bit = bit_cnt == BW'(SUM_WIDTH - 1);
  assign enough   = (cnt >= CNT_WIDTH'(MIN_COUNT)) && (cnt != '0);

  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_end) state_nx = enough ? DIV_X : DONE;
      DIV_X:   if (last_bit)  state_nx = DIV_Y;
      DIV_Y:   if (last_bit)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      dq <= '0; hold_y <= '0; hold_cnt <= '0; q_x <= '0;
      rem <= '0; bit_cnt <= '0; found <= 1'b0;
    end else begin
      case (state)
        IDLE: if (frame_end) begin
          dq <= sum_x; hold_y <= sum_y; hold_cnt <= cnt; found <= enough;
          rem <= '0; bit_cnt <= '0;
        end
        DIV_X, DIV_Y: begin
          if (last_bit && state == DIV_X) begin
            q_x <= dq_nx; dq <= hold_y; rem <= '0; bit_cnt <= '0;
          end else begin
            dq  <= dq_nx;
            rem <= q_bit ? rem_diff[CNT_WIDTH-1:0] : rem_sh[CNT_WIDTH-1:0];
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        default: ;
      endcase
    end

  // in DONE, dq holds the y quotient
  logic [X_WIDTH-1:0]   sat_x, pt_x;
  logic [Y_WIDTH-1:0]   sat_y, pt_y;
  logic [CNT_WIDTH-1:0] o_count;
  logic                 o_valid, o_found, o_drop;
  assign sat_x = (q_x > SUM_WIDTH'({X_WIDTH{1'b1}})) ? {X_WIDTH{1'b1}} : q_x[X_WIDTH-1:0];
  assign sat_y = (dq  > SUM_WIDTH'({Y_WIDTH{1'b1}})) ? {Y_WIDTH{1'b1}} : dq[Y_WIDTH-1:0];

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      pt_x <= '0; pt_y <= '0; o_count <= '0;
      o_valid <= 1'b0; o_found <= 1'b0; o_drop <= 1'b0;
    end else begin
      o_valid <= state == DONE;
      o_drop  <= frame_end && (state != IDLE);
      if (state == DONE) begin
        o_count <= hold_cnt;
        o_found <= found;
        if (found) begin
          pt_x <= sat_x;
          pt_y <= sat_y;
        end
      end
    end

  assign bus.oPOINT_X = pt_x;
  assign bus.oPOINT_Y = pt_y;
  assign bus.oCOUNT   = o_count;
  assign bus.oVALID   = o_valid;
  assign bus.oFOUND   = o_found;
  assign bus.oDROP    = o_drop;
  assign bus.oBUSY    = (state == DIV_X) || (state == DIV_Y);
endmodule

// File: tb/tb_pupil_centroid.sv
// Scoreboard bench for pupil_centroid: directed frames, expected results queued at frame end.
module tb_pupil_centroid;
  localparam int XW = 10, YW = 10, CW = 19, SW = 29;
  // MIN_COUNT=2 so a 2-pixel frame is found while a 1-pixel frame is not
  localparam int MINC = 2;
  localparam int LAT_FOUND = 2 * SW + 3;
  localparam int LAT_MISS  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pupil_centroid_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .CNT_WIDTH(CW)) bus();

  pupil_centroid #(.X_WIDTH(XW), .Y_WIDTH(YW), .CNT_WIDTH(CW), .SUM_WIDTH(SW),
                   .MIN_COUNT(MINC)) dut (.CLK(clk), .RST(rst), .bus(bus));

  typedef struct {
    int cyc; int cnt; int x; int y; int found;
  } exp_t;

  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0, drops = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.oDROP) drops++;
    if (bus.oVALID) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", cyc, e.cyc);
        chk("count", bus.oCOUNT, e.cnt);
        chk("point_x", bus.oPOINT_X, e.x);
        chk("point_y", bus.oPOINT_Y, e.y);
        chk("found", bus.oFOUND, e.found);
      end
    end
  end

  function automatic bit in_r(input int x, y, x0, x1, y0, y1);
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

  task automatic run_frame(input int nlines, nb, nb_last,
                           input int ax0, ax1, ay0, ay1, bx0, bx1, by0, by1,
                           output int t_end);
    bus.iFVAL = 1'b1;
    repeat (2) @(negedge clk);
    for (int yy = 0; yy < nlines; yy++) begin
      int n;
      n = (yy == nlines - 1) ? nb_last : nb;
      for (int c = 0; c < n; c++) begin
        bus.iLVAL = 1'b1; bus.iDVAL = 1'b1;
        bus.iDATA_L = (in_r(2*c, yy, ax0, ax1, ay0, ay1) || in_r(2*c, yy, bx0, bx1, by0, by1))
                      ? 8'h00 : 8'hFF;
        bus.iDATA_R = (in_r(2*c+1, yy, ax0, ax1, ay0, ay1) || in_r(2*c+1, yy, bx0, bx1, by0, by1))
                      ? 8'h00 : 8'hFF;
        @(negedge clk);
      end
      bus.iLVAL = 1'b0; bus.iDVAL = 1'b0; bus.iDATA_L = 8'hFF; bus.iDATA_R = 8'hFF;
      repeat (2) @(negedge clk);
    end
    bus.iFVAL = 1'b0;
    t_end = cyc;
    @(negedge clk);
  endtask

  task automatic expect_res(input int t, lat, cnt, x, y, found);
    sb.push_back('{t + lat, cnt, x, y, found});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int t;
    bus.iFVAL = 1'b0; bus.iLVAL = 1'b0; bus.iDVAL = 1'b0;
    bus.iDATA_L = 8'hFF; bus.iDATA_R = 8'hFF; bus.iTHRESHOLD = 8'h80;
`ifdef CENTROID_ROI_EN
    bus.iROI_X0 = '0; bus.iROI_X1 = '1; bus.iROI_Y0 = '0; bus.iROI_Y1 = '1;
`endif
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.oVALID, 0);
    chk("rst_point", {bus.oPOINT_X, bus.oPOINT_Y}, 0);
    chk("rst_count", bus.oCOUNT, 0);
    chk("rst_flags", {bus.oFOUND, bus.oBUSY, bus.oDROP}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 4x4 dark block at x=200..203, y=10..13
    run_frame(14, 102, 102, 200, 203, 10, 13, 1, 0, 1, 0, t);
    expect_res(t, LAT_FOUND, 16, 201, 11, 1);
    wait_drain();

    // single dark pixel: below MIN_COUNT, point holds
    run_frame(51, 51, 51, 100, 100, 50, 50, 1, 0, 1, 0, t);
    expect_res(t, LAT_MISS, 1, 201, 11, 0);
    wait_drain();

    // both taps dark on the last beat of line 479
    run_frame(480, 1, 320, 638, 639, 479, 479, 1, 0, 1, 0, t);
    expect_res(t, LAT_FOUND, 2, 638, 479, 1);
    wait_drain();

    // reset while dividing: no result, outputs cleared
    run_frame(14, 102, 102, 200, 203, 10, 13, 1, 0, 1, 0, t);
    repeat (8) @(negedge clk);
    chk("busy_mid_div", bus.oBUSY, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_point", {bus.oPOINT_X, bus.oPOINT_Y}, 0);
    chk("rst_mid_count", bus.oCOUNT, 0);
    chk("rst_mid_flags", {bus.oVALID, bus.oFOUND, bus.oBUSY, bus.oDROP}, 0);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    chk("idle_after_rst", bus.oBUSY, 0);

    // 2x2 block, then a short frame ends while the divider is busy
    run_frame(6, 6, 6, 10, 11, 4, 5, 1, 0, 1, 0, t);
    expect_res(t, LAT_FOUND, 4, 10, 4, 1);
    run_frame(2, 2, 2, 1, 0, 1, 0, 1, 0, 1, 0, t);
    wait_drain();
    repeat (5) @(negedge clk);
    chk("drop_count", drops, 1);

`ifdef CENTROID_ROI_EN
    bus.iROI_X0 = 10'd0; bus.iROI_X1 = 10'd199; bus.iROI_Y0 = 10'd0; bus.iROI_Y1 = 10'd479;
    run_frame(24, 152, 152, 50, 53, 20, 23, 300, 303, 20, 23, t);
    expect_res(t, LAT_FOUND, 16, 51, 21, 1);
    wait_drain();
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
